decode_pipe: RTL

//  Parametrised pipelined decode stage for the WISC pipeline. Sits between the IF/ID and ID/EX

---
 rtl/decode_pipe.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_pipe.sv
// WISC decode stage: instruction decode, immediate extension, register file with optional
// write-back bypass, load-use / branch-operand stalls, ID-stage branch resolution, ID/EX register.
module decode_pipe #(
    parameter int  DATA_W       = 16,
    parameter int  NUM_REGS     = 8,
    parameter bit  BYPASS_WB    = 1'b1,
    parameter bit  BRANCH_IN_ID = 1'b1,
    localparam int REG_AW       = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [15:0]       if_instr,
    input  logic [DATA_W-1:0] if_pc,
    input  logic [DATA_W-1:0] if_pc_inc,
    output logic              id_ready,
    input  logic              ex_ready,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_sel,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] mem_wsel,
    output logic              redirect_valid,
    output logic [DATA_W-1:0] redirect_pc,
    output logic              halted,
    output logic              ex_valid,
    output logic [11:0]       ex_ctrl,
    output logic [3:0]        ex_aluop,
    output logic [DATA_W-1:0] ex_rs_val,
    output logic [DATA_W-1:0] ex_rt_val,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc_inc,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_wsel
);

    typedef struct packed {
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
        logic alu_src;
        logic reg_write;
        logic write_r7;
        logic jump_reg;
        logic jump;
        logic branch;
        logic nop;
        logic halt;
        logic is_br;
    } ctrl_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_XOR, ALU_ANDN, ALU_ROL, ALU_SLL, ALU_ROR, ALU_SRL,
        ALU_SEQ, ALU_SLT, ALU_SLE, ALU_SCO, ALU_BTR, ALU_LBI, ALU_SLBI, ALU_PASS
    } aluop_t;

    logic [4:0]        w_opcode;
    logic [REG_AW-1:0] w_rs, w_rt, w_rd, w_r7, w_wsel;
    logic [DATA_W-1:0] w_sext5, w_zext5, w_sext8, w_zext8, w_sext11, w_imm;
    logic [DATA_W-1:0] w_rs_val, w_rt_val;
    ctrl_t             w_ctrl;
    aluop_t            w_aluop;
    logic              w_rs_used, w_rt_used, w_cond, w_taken;
    logic              w_load_use, w_br_stall, w_stall, w_transfer;
    logic              w_unused_pc;

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              r_halted, r_ex_valid;
    ctrl_t             r_ex_ctrl;
    aluop_t            r_ex_aluop;
    logic [DATA_W-1:0] r_ex_rs_val, r_ex_rt_val, r_ex_imm, r_ex_pc_inc;
    logic [REG_AW-1:0] r_ex_rs, r_ex_rt, r_ex_wsel;

    // Targets are formed from pc_inc; the raw PC is carried only for interface symmetry.
    assign w_unused_pc = ^if_pc;

    assign w_opcode = if_instr[15:11];
    assign w_rs     = REG_AW'(if_instr[10:8]);
    assign w_rt     = REG_AW'(if_instr[7:5]);
    assign w_rd     = REG_AW'(if_instr[4:2]);
    assign w_r7     = REG_AW'(7);
    assign w_sext5  = DATA_W'($signed(if_instr[4:0]));
    assign w_zext5  = DATA_W'(if_instr[4:0]);
    assign w_sext8  = DATA_W'($signed(if_instr[7:0]));
    assign w_zext8  = DATA_W'(if_instr[7:0]);
    assign w_sext11 = DATA_W'($signed(if_instr[10:0]));

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_ctrl    = '0;
        w_aluop   = ALU_ADD;
        w_imm     = '0;
        w_wsel    = '0;
        w_rs_used = 1'b0;
        w_rt_used = 1'b0;
        case (w_opcode)
            5'b00000: w_ctrl.halt = 1'b1;
            5'b01000, 5'b01001, 5'b01010, 5'b01011,
            5'b10100, 5'b10101, 5'b10110, 5'b10111: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_rs_used        = 1'b1;
                w_wsel           = w_rt;
                w_aluop          = aluop_t'({1'b0, w_opcode[4], w_opcode[1:0]});
                w_imm            = (w_opcode[4:1] == 4'b0100) ? w_sext5 : w_zext5;
            end
            5'b11010, 5'b11011, 5'b11100, 5'b11101, 5'b11110, 5'b11111: begin
                w_ctrl.reg_write = 1'b1;
                w_rs_used        = 1'b1;
                w_rt_used        = 1'b1;
                w_wsel           = w_rd;
                w_aluop          = w_opcode[2] ? aluop_t'({2'b10, w_opcode[1:0]})
                                               : aluop_t'({1'b0, ~w_opcode[0], if_instr[1:0]});
            end
            5'b11001: begin
                w_ctrl.reg_write = 1'b1;
                w_rs_used        = 1'b1;
                w_wsel           = w_rd;
                w_aluop          = ALU_BTR;
            end
            5'b10000, 5'b10011: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = w_opcode[1];
                w_rs_used        = 1'b1;
                w_rt_used        = 1'b1;
                w_wsel           = w_opcode[1] ? w_rs : '0;
                w_imm            = w_sext5;
            end
            5'b10001: begin
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.mem_read   = 1'b1;
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.reg_write  = 1'b1;
                w_rs_used         = 1'b1;
                w_wsel            = w_rt;
                w_imm             = w_sext5;
            end
            5'b11000, 5'b10010: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_rs_used        = w_opcode[1];
                w_wsel           = w_rs;
                w_aluop          = w_opcode[1] ? ALU_SLBI : ALU_LBI;
                w_imm            = w_opcode[1] ? w_zext8 : w_sext8;
            end
            5'b01100, 5'b01101, 5'b01110, 5'b01111: begin
                w_ctrl.branch = 1'b1;
                w_rs_used     = 1'b1;
                w_imm         = w_sext8;
            end
            5'b00100, 5'b00110: begin
                w_ctrl.jump      = 1'b1;
                w_ctrl.reg_write = w_opcode[1];
                w_ctrl.write_r7  = w_opcode[1];
                w_wsel           = w_opcode[1] ? w_r7 : '0;
                w_aluop          = w_opcode[1] ? ALU_PASS : ALU_ADD;
                w_imm            = w_sext11;
            end
            5'b00101, 5'b00111: begin
                w_ctrl.jump_reg  = 1'b1;
                w_ctrl.reg_write = w_opcode[1];
                w_ctrl.write_r7  = w_opcode[1];
                w_rs_used        = 1'b1;
                w_wsel           = w_opcode[1] ? w_r7 : '0;
                w_aluop          = w_opcode[1] ? ALU_PASS : ALU_ADD;
                w_imm            = w_sext8;
            end
            default: w_ctrl.nop = 1'b1;
        endcase
        w_ctrl.is_br = !BRANCH_IN_ID && (w_ctrl.branch || w_ctrl.jump || w_ctrl.jump_reg);
    end

    assign w_rs_val = (BYPASS_WB && wb_en && wb_sel == w_rs) ? wb_data : r_regs[w_rs];
    assign w_rt_val = (BYPASS_WB && wb_en && wb_sel == w_rt) ? wb_data : r_regs[w_rt];

    always_comb begin
        case (w_opcode[1:0])
            2'b00:   w_cond = (w_rs_val == '0);
            2'b01:   w_cond = (w_rs_val != '0);
            2'b10:   w_cond = w_rs_val[DATA_W-1];
            default: w_cond = ~w_rs_val[DATA_W-1];
        endcase
    end
    assign w_taken = w_ctrl.branch & w_cond;

    assign w_load_use = r_ex_valid & r_ex_ctrl.mem_read & r_ex_ctrl.reg_write &
                        ((w_rs_used & (r_ex_wsel == w_rs)) | (w_rt_used & (r_ex_wsel == w_rt)));
    // Branch operands are consumed in ID, so any older in-flight writer of rs must drain to WB.
    assign w_br_stall = BRANCH_IN_ID & (w_ctrl.branch | w_ctrl.jump_reg) &
                        ((r_ex_valid & r_ex_ctrl.reg_write & (r_ex_wsel == w_rs)) |
                         (mem_regwrite & (mem_wsel == w_rs)));
    assign w_stall    = if_valid & (w_load_use | w_br_stall);
    assign id_ready   = ex_ready & ~w_stall & ~r_halted;
    assign w_transfer = if_valid & id_ready;

    assign redirect_valid = BRANCH_IN_ID & w_transfer & (w_taken | w_ctrl.jump | w_ctrl.jump_reg);
    assign redirect_pc    = (w_ctrl.jump_reg ? w_rs_val : if_pc_inc) + w_imm;

    // NOTE: the register file must read as zero after reset, so it is reset like any
    // other flop array and cannot map onto a RAM macro.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (wb_en) begin
            r_regs[wb_sel] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_halted    <= 1'b0;
            r_ex_valid  <= 1'b0;
            r_ex_ctrl   <= '0;
            r_ex_aluop  <= ALU_ADD;
            r_ex_rs_val <= '0;
            r_ex_rt_val <= '0;
            r_ex_imm    <= '0;
            r_ex_pc_inc <= '0;
            r_ex_rs     <= '0;
            r_ex_rt     <= '0;
            r_ex_wsel   <= '0;
        end else if (ex_ready) begin
            if (w_transfer) begin
                r_halted    <= r_halted | w_ctrl.halt;
                r_ex_valid  <= 1'b1;
                r_ex_ctrl   <= w_ctrl;
                r_ex_aluop  <= w_aluop;
                r_ex_rs_val <= w_rs_val;
                r_ex_rt_val <= w_rt_val;
                r_ex_imm    <= w_imm;
                r_ex_pc_inc <= if_pc_inc;
                r_ex_rs     <= w_rs;
                r_ex_rt     <= w_rt;
                r_ex_wsel   <= w_wsel;
            end else begin
                r_ex_valid  <= 1'b0;
                r_ex_ctrl   <= '0;
                r_ex_aluop  <= ALU_ADD;
                r_ex_rs_val <= '0;
                r_ex_rt_val <= '0;
                r_ex_imm    <= '0;
                r_ex_pc_inc <= '0;
                r_ex_rs     <= '0;
                r_ex_rt     <= '0;
                r_ex_wsel   <= '0;
            end
        end
    end

    assign halted    = r_halted;
    assign ex_valid  = r_ex_valid;
    assign ex_ctrl   = r_ex_ctrl;
    assign ex_aluop  = r_ex_aluop;
    assign ex_rs_val = r_ex_rs_val;
    assign ex_rt_val = r_ex_rt_val;
    assign ex_imm    = r_ex_imm;
    assign ex_pc_inc = r_ex_pc_inc;
    assign ex_rs     = r_ex_rs;
    assign ex_rt     = r_ex_rt;
    assign ex_wsel   = r_ex_wsel;

endmodule
